eth_frame_reader: RTL

ETH_FRAME_READER -- requirements
Module: eth_frame_reader

---
 rtl/eth_frame_reader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_frame_reader.sv
`default_nettype none
// ============================================================================
// eth_frame_reader : streams preamble/SFD, buffered payload, CRC-32 FCS, IFG
// Revision 1.0
// ============================================================================
module eth_frame_reader #(
  parameter int ETH_DATA_SIZE = 1280,
  parameter int HDR_SIZE      = 50,
  parameter int IFG_CYCLES    = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [10:0] frame_len,
  output logic        ram_rd_en,
  output logic [10:0] ram_addr,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        eth_finish
);

  localparam int IFG_W = (IFG_CYCLES > 15) ? $clog2(IFG_CYCLES + 1) : 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_FCS  = 3'd3;
  localparam logic [2:0] S_IFG  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  generate
    if ((HDR_SIZE + ETH_DATA_SIZE > 2047) || (IFG_CYCLES < 1)) begin : g_param_check
      $error("eth_frame_reader: unsupported parameter values");
    end
  endgenerate

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  logic [2:0]       r_state;
  logic [10:0]      r_len;
  logic [2:0]       r_pre_cnt;
  logic [10:0]      r_byte_cnt;
  logic [1:0]       r_fcs_cnt;
  logic [IFG_W-1:0] r_ifg_cnt;
  logic [10:0]      r_addr;
  logic             r_rd_q;
  logic [7:0]       r_buf0;
  logic [7:0]       r_buf1;
  logic [1:0]       r_buf_cnt;
  logic [31:0]      r_crc;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;

  logic             w_adv;
  logic             w_pop;
  logic [2:0]       w_occ;
  logic             w_rd_en;
  logic             w_last;
  logic [31:0]      w_fcs;
  logic [7:0]       w_fcs_byte;

  assign w_adv = !r_tx_valid || tx_ready;
  assign w_pop = (r_state == S_DATA) && w_adv && (r_buf_cnt != 2'd0);
  // A read in flight already owns a holding slot; a same-cycle pop frees one.
  assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_rd_q};
  assign w_rd_en = ((r_state == S_PRE) || (r_state == S_DATA)) && (r_addr != r_len) &&
                   ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));
  assign w_last  = (r_byte_cnt == (r_len - 11'd1));
  assign w_fcs   = ~r_crc;

  always_comb begin
    w_fcs_byte = w_fcs[7:0];
    case (r_fcs_cnt)
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      2'd3:    w_fcs_byte = w_fcs[31:24];
      default: w_fcs_byte = w_fcs[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_len      <= 11'd0;
      r_pre_cnt  <= 3'd0;
      r_byte_cnt <= 11'd0;
      r_fcs_cnt  <= 2'd0;
      r_ifg_cnt  <= '0;
      r_addr     <= 11'd0;
      r_rd_q     <= 1'b0;
      r_buf0     <= 8'h00;
      r_buf1     <= 8'h00;
      r_buf_cnt  <= 2'd0;
      r_crc      <= 32'hFFFFFFFF;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      r_rd_q <= w_rd_en;
      if (w_rd_en) r_addr <= r_addr + 11'd1;

      case ({r_rd_q, w_pop})
        2'b10: begin
          if (r_buf_cnt == 2'd0) r_buf0 <= ram_dout;
          else                   r_buf1 <= ram_dout;
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf0 <= ram_dout;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= ram_dout;
          end
        end
        default: ;
      endcase

      case (r_state)
        S_IDLE: begin
          if (start && (frame_len != 11'd0)) begin
            r_state    <= S_PRE;
            r_len      <= frame_len;
            r_tx_valid <= 1'b1;
            r_tx_data  <= 8'h55;
            r_pre_cnt  <= 3'd1;
            r_byte_cnt <= 11'd0;
            r_fcs_cnt  <= 2'd0;
            r_ifg_cnt  <= '0;
            r_crc      <= 32'hFFFFFFFF;
            r_addr     <= 11'd0;
          end
        end
        S_PRE: begin
          if (w_adv) begin
            if (r_pre_cnt == 3'd7) begin
              r_tx_data <= 8'hD5;
              r_state   <= S_DATA;
            end else begin
              r_tx_data <= 8'h55;
              r_pre_cnt <= r_pre_cnt + 3'd1;
            end
          end
        end
        S_DATA: begin
          if (w_pop) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_buf0;
            r_crc      <= crc_step(r_crc, r_buf0);
            if (w_last) r_state    <= S_FCS;
            else        r_byte_cnt <= r_byte_cnt + 11'd1;
          end else if (w_adv) begin
            r_tx_valid <= 1'b0;
          end
        end
        S_FCS: begin
          if (w_adv) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_fcs_byte;
            if (r_fcs_cnt == 2'd3) r_state   <= S_IFG;
            else                   r_fcs_cnt <= r_fcs_cnt + 2'd1;
          end
        end
        S_IFG: begin
          // The gap only starts counting once the last FCS byte has been taken.
          if (r_tx_valid) begin
            if (tx_ready) r_tx_valid <= 1'b0;
          end else if (r_ifg_cnt == IFG_W'(IFG_CYCLES - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_ifg_cnt <= r_ifg_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_addr  <= 11'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_rd_en  = w_rd_en;
  assign ram_addr   = r_addr;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign busy       = (r_state != S_IDLE);
  assign eth_finish = (r_state == S_DONE);

endmodule
`default_nettype wire
